// File: rtl/palette_pkg.sv
// Shared types for the palette write controller: sizes, FSM states and the
// {addr, data} write payload carried by the FIFO and the grant mux.
package palette_pkg;

  localparam int unsigned PAL_ENTRIES = 32;
  localparam int unsigned PAL_AW      = 5;
  localparam int unsigned PAL_DW      = 8;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } pal_state_e;

  typedef struct packed {
    logic [PAL_AW-1:0] addr;
    logic [PAL_DW-1:0] data;
  } pal_wr_t;

  // Palette pointer advance; wraps 31 -> 0 through the 5-bit width.
  function automatic logic [PAL_AW-1:0] pal_next_addr(input logic [PAL_AW-1:0] a);
    return a + PAL_AW'(1);
  endfunction

endpackage

// File: rtl/palette_wr_fifo.sv
// Small synchronous FIFO of palette writes; a pop in the same cycle frees a
// slot for a push, so a full FIFO that is being drained still accepts.
module palette_wr_fifo
  import palette_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  pal_wr_t wr_data,
  input  logic    pop,
  output pal_wr_t rd_data_c,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  pal_wr_t         mem_q [DEPTH];
  pal_wr_t         mem_d [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            full_q, full_d;
  logic            empty_q, empty_d;
  logic            do_push;
  logic            do_pop;

  // Pointer, occupancy and storage update.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    do_pop  = pop && !empty_q;
    do_push = push && (!full_q || do_pop);
    if (do_push) begin
      mem_d[wr_q] = wr_data;
      wr_d        = wr_q + AW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + AW'(1);
    end
    cnt_d   = cnt_q + CW'(do_push) - CW'(do_pop);
    full_d  = (cnt_d == CW'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rd_data_c = mem_q[rd_q];
  assign full      = full_q;
  assign empty     = empty_q;

endmodule

// File: rtl/palette_wr_arbiter.sv
// Palette RAM write-port controller: power-up clear, CPU pointer + FIFO path
// and host valid/ready path. Clear sequence compiled in with PALETTE_CLEAR_EN.
module palette_wr_arbiter
  import palette_pkg::*;
#(
  parameter int unsigned       FIFO_DEPTH   = 2,
  parameter int unsigned       STARVE_LIMIT = 4,
  parameter logic [PAL_DW-1:0] CLEAR_VALUE  = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_addr_load,
  input  logic [PAL_AW-1:0] cpu_addr_val,
  input  logic              cpu_wr,
  input  logic [PAL_DW-1:0] cpu_wrdata,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [PAL_AW-1:0] host_addr,
  input  logic [PAL_DW-1:0] host_wrdata,
  output logic [PAL_AW-1:0] pal_addr,
  output logic [PAL_DW-1:0] pal_wrdata,
  output logic              pal_wren,
  output logic [PAL_AW-1:0] cpu_ptr,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

`ifdef PALETTE_CLEAR_EN
  localparam pal_state_e ST_RESET   = ST_CLEAR;
  localparam logic       BUSY_RESET = 1'b1;
`else
  localparam pal_state_e ST_RESET   = ST_RUN;
  localparam logic       BUSY_RESET = 1'b0;
`endif

  pal_state_e        state_q, state_d;
  pal_wr_t           pal_q, pal_d;
  logic              wren_q, wren_d;
  logic              busy_q, busy_d;
  logic [PAL_AW-1:0] ptr_q, ptr_d;
  logic              ovf_q, ovf_d;
  logic [SW-1:0]     starve_q, starve_d;
`ifdef PALETTE_CLEAR_EN
  logic [PAL_AW-1:0] clr_cnt_q, clr_cnt_d;
`endif

  logic              grant_host;
  logic              grant_cpu;
  logic              fifo_push;
  logic              fifo_pop;
  pal_wr_t           fifo_wr;
  pal_wr_t           fifo_rd;
  logic              fifo_full;
  logic              fifo_empty;

  palette_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (fifo_push),
    .wr_data   (fifo_wr),
    .pop       (fifo_pop),
    .rd_data_c (fifo_rd),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // FSM next state, write-port grant and registered palette outputs.
  always_comb begin
    state_d    = state_q;
    pal_d      = pal_q;
    wren_d     = 1'b0;
    busy_d     = 1'b0;
    starve_d   = '0;
    grant_host = 1'b0;
    grant_cpu  = 1'b0;
`ifdef PALETTE_CLEAR_EN
    clr_cnt_d  = clr_cnt_q;
`endif
    case (state_q)
      ST_CLEAR: begin
`ifdef PALETTE_CLEAR_EN
        wren_d     = 1'b1;
        busy_d     = 1'b1;
        pal_d      = '{addr: clr_cnt_q, data: CLEAR_VALUE};
        clr_cnt_d  = pal_next_addr(clr_cnt_q);
        if (clr_cnt_q == PAL_AW'(PAL_ENTRIES - 1)) begin
          state_d = ST_RUN;
        end
`else
        pal_d.data = CLEAR_VALUE;
        state_d    = ST_RUN;
`endif
      end
      ST_RUN: begin
        // Host wins when the FIFO is idle or the CPU has hit its streak limit.
        grant_host = host_valid && (fifo_empty || (starve_q >= SW'(STARVE_LIMIT)));
        grant_cpu  = !fifo_empty && !grant_host;
        if (grant_host) begin
          wren_d = 1'b1;
          pal_d  = '{addr: host_addr, data: host_wrdata};
        end else if (grant_cpu) begin
          wren_d   = 1'b1;
          pal_d    = fifo_rd;
          starve_d = host_valid ? (starve_q + SW'(1)) : '0;
        end
      end
    endcase
  end

  // CPU pointer follows VDP semantics: it advances even when the write drops.
  always_comb begin
    ptr_d     = ptr_q;
    fifo_push = cpu_wr;
    fifo_wr   = '{addr: (cpu_addr_load ? cpu_addr_val : ptr_q), data: cpu_wrdata};
    if (cpu_wr) begin
      ptr_d = pal_next_addr(fifo_wr.addr);
    end else if (cpu_addr_load) begin
      ptr_d = cpu_addr_val;
    end
    ovf_d = ovf_q || (cpu_wr && fifo_full && !fifo_pop);
  end

  assign fifo_pop = grant_cpu;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_RESET;
      pal_q     <= '0;
      wren_q    <= 1'b0;
      busy_q    <= BUSY_RESET;
      ptr_q     <= '0;
      ovf_q     <= 1'b0;
      starve_q  <= '0;
`ifdef PALETTE_CLEAR_EN
      clr_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pal_q     <= pal_d;
      wren_q    <= wren_d;
      busy_q    <= busy_d;
      ptr_q     <= ptr_d;
      ovf_q     <= ovf_d;
      starve_q  <= starve_d;
`ifdef PALETTE_CLEAR_EN
      clr_cnt_q <= clr_cnt_d;
`endif
    end
  end

  assign host_ready = grant_host;
  assign pal_addr   = pal_q.addr;
  assign pal_wrdata = pal_q.data;
  assign pal_wren   = wren_q;
  assign cpu_ptr    = ptr_q;
  assign busy       = busy_q;
  assign overflow   = ovf_q;

endmodule
